// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and MDU results onto the single register-file write port; registered output (1-cycle latency), ALU never stalls,
// MDU backpressured via mdu_wready when the write buffer is full. Optional forwarding lookup ports under WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          alu_wvalid,
  input  logic [4:0]    alu_waddr,
  input  logic [31:0]   alu_wdata,
  input  logic          mdu_wvalid,
  output logic          mdu_wready,
  input  logic [4:0]    mdu_waddr,
  input  logic [31:0]   mdu_wdata,
  output logic          regfile_write,
  output logic [4:0]    rdc,
  output logic [31:0]   rd,
  output logic [31:0]   pend_mask,
  output logic [AW:0]   fifo_count
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]    fwd_addr,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             we_q, we_d;
  logic [4:0]       rdc_q, rdc_d;
  logic [31:0]      rd_q, rd_d;

  logic hs, fifo_empty, pop, direct, push, push_live, alu_kill;

  assign mdu_wready = (count_q < DEPTH_C);
  assign hs         = mdu_wvalid && mdu_wready;
  assign fifo_empty = (count_q == '0);
  assign pop        = !alu_wvalid && !fifo_empty;
  assign direct     = !alu_wvalid && fifo_empty && hs;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push       = hs && !direct && (mdu_waddr != 5'd0);
  assign alu_kill   = alu_wvalid && (alu_waddr != 5'd0);
  // ALU is the younger producer, so a same-cycle MDU result to the same register is dead on arrival.
  assign push_live  = !(alu_kill && (alu_waddr == mdu_waddr));

  always_comb begin
    we_d  = 1'b0;
    rdc_d = rdc_q;
    rd_d  = rd_q;
    if (alu_wvalid) begin
      if (alu_waddr != 5'd0) begin
        we_d  = 1'b1;
        rdc_d = alu_waddr;
        rd_d  = alu_wdata;
      end
    end else if (pop) begin
      if (live_q[rd_ptr_q]) begin
        we_d  = 1'b1;
        rdc_d = addr_q[rd_ptr_q];
        rd_d  = data_q[rd_ptr_q];
      end
    end else if (direct && (mdu_waddr != 5'd0)) begin
      we_d  = 1'b1;
      rdc_d = mdu_waddr;
      rd_d  = mdu_wdata;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (alu_kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == alu_waddr) live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end
    if (push) begin
      addr_d[wr_ptr_q] = mdu_waddr;
      data_d[wr_ptr_q] = mdu_wdata;
      live_d[wr_ptr_q] = push_live;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      rdc_q    <= 5'd0;
      rd_q     <= 32'd0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      rdc_q    <= rdc_d;
      rd_q     <= rd_d;
    end
  end

  // Popped and killed entries have live cleared, so live alone marks a pending buffered write.
  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign regfile_write = we_q;
  assign rdc           = rdc_q;
  assign rd            = rd_q;
  assign fifo_count    = count_q;

`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest live match wins; output stage is the fallback.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    fwd_idx  = '0;
    if (fwd_addr != 5'd0) begin
      if (we_q && (rdc_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rd_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        fwd_idx = rd_ptr_q + AW'(k);
        if (live_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven 1ns after the rising edge, outputs checked at that point.
module tb_regfile_wb_arbiter;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b1;
  logic        alu_wvalid = 1'b0;
  logic [4:0]  alu_waddr = 5'd0;
  logic [31:0] alu_wdata = 32'd0;
  logic        mdu_wvalid = 1'b0;
  logic        mdu_wready;
  logic [4:0]  mdu_waddr = 5'd0;
  logic [31:0] mdu_wdata = 32'd0;
  logic        regfile_write;
  logic [4:0]  rdc;
  logic [31:0] rd;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr = 5'd0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int passes = 0;

  regfile_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .alu_wvalid(alu_wvalid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mdu_wvalid(mdu_wvalid), .mdu_wready(mdu_wready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .regfile_write(regfile_write), .rdc(rdc), .rd(rd),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
`ifdef WB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle();
    alu_wvalid = 1'b0;
    mdu_wvalid = 1'b0;
  endtask

  task automatic test_reset();
    #2 wb_rst_n = 1'b0;
    #1;
    checks++; if (regfile_write !== 1'b0) $display("FAIL rst_we got=%b exp=0", regfile_write); else passes++;
    checks++; if (rdc !== 5'd0) $display("FAIL rst_rdc got=%0d exp=0", rdc); else passes++;
    checks++; if (rd !== 32'd0) $display("FAIL rst_rd got=%h exp=0", rd); else passes++;
    checks++; if (pend_mask !== 32'd0) $display("FAIL rst_pend got=%h exp=0", pend_mask); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", fifo_count); else passes++;
    tick();
    tick();
    wb_rst_n = 1'b1;
    tick();
    checks++; if (mdu_wready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", mdu_wready); else passes++;
  endtask

  task automatic test_mdu_direct();
    mdu_wvalid = 1'b1; mdu_waddr = 5'd5; mdu_wdata = 32'h1234_5678;
    checks++; if (mdu_wready !== 1'b1) $display("FAIL direct_ready got=%b exp=1", mdu_wready); else passes++;
    tick();
    idle();
    checks++; if (regfile_write !== 1'b1) $display("FAIL direct_we got=%b exp=1", regfile_write); else passes++;
    checks++; if (rdc !== 5'd5) $display("FAIL direct_rdc got=%0d exp=5", rdc); else passes++;
    checks++; if (rd !== 32'h1234_5678) $display("FAIL direct_rd got=%h exp=12345678", rd); else passes++;
    checks++; if (pend_mask !== 32'd0) $display("FAIL direct_pend got=%h exp=0", pend_mask); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL direct_count got=%0d exp=0", fifo_count); else passes++;
    tick();
    checks++; if (regfile_write !== 1'b0) $display("FAIL direct_idle_we got=%b exp=0", regfile_write); else passes++;
  endtask

  task automatic test_collide();
    int          next_mdu;
    logic        hs;
    int          exp_reg;
    logic [31:0] exp_dat;
    logic [31:0] exp_pend [12];
    int          exp_cnt [12];
    logic        exp_rdy [9];
    exp_pend = '{32'h100, 32'h300, 32'h700, 32'hF00, 32'hF00, 32'hF00,
                 32'hE00, 32'h1C00, 32'h3800, 32'h3000, 32'h2000, 32'h0};
    exp_cnt  = '{1, 2, 3, 4, 4, 4, 3, 3, 3, 2, 1, 0};
    exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    next_mdu = 8;
    for (int c = 0; c < 12; c++) begin
      alu_wvalid = (c < 6);
      alu_waddr  = 5'(c + 1);
      alu_wdata  = 32'hA000_0000 | 32'(c + 1);
      mdu_wvalid = (next_mdu <= 13);
      mdu_waddr  = 5'(next_mdu);
      mdu_wdata  = 32'hB000_0000 | 32'(next_mdu);
      if (c < 9) begin
        checks++; if (mdu_wready !== exp_rdy[c]) $display("FAIL coll_ready c=%0d got=%b exp=%b", c, mdu_wready, exp_rdy[c]); else passes++;
      end
      hs = mdu_wvalid && mdu_wready;
      tick();
      if (hs) next_mdu++;
      exp_reg = (c < 6) ? c + 1 : c + 2;
      exp_dat = ((c < 6) ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_reg);
      checks++; if (regfile_write !== 1'b1) $display("FAIL coll_we c=%0d got=%b exp=1", c, regfile_write); else passes++;
      checks++; if (rdc !== 5'(exp_reg)) $display("FAIL coll_rdc c=%0d got=%0d exp=%0d", c, rdc, exp_reg); else passes++;
      checks++; if (rd !== exp_dat) $display("FAIL coll_rd c=%0d got=%h exp=%h", c, rd, exp_dat); else passes++;
      checks++; if (fifo_count !== 3'(exp_cnt[c])) $display("FAIL coll_count c=%0d got=%0d exp=%0d", c, fifo_count, exp_cnt[c]); else passes++;
      checks++; if (pend_mask !== exp_pend[c]) $display("FAIL coll_pend c=%0d got=%h exp=%h", c, pend_mask, exp_pend[c]); else passes++;
    end
    idle();
  endtask

  task automatic test_waw();
    alu_wvalid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1;
    mdu_wvalid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'hAAAA;
    tick();
    checks++; if (pend_mask !== 32'h80) $display("FAIL waw_pend_set got=%h exp=80", pend_mask); else passes++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL waw_count got=%0d exp=1", fifo_count); else passes++;
    alu_waddr = 5'd7; alu_wdata = 32'hBBBB; mdu_wvalid = 1'b0;
    tick();
    idle();
    checks++; if (pend_mask !== 32'h0) $display("FAIL waw_pend_clr got=%h exp=0", pend_mask); else passes++;
    checks++; if (regfile_write !== 1'b1 || rdc !== 5'd7 || rd !== 32'hBBBB)
      $display("FAIL waw_alu_wr got=%b/%0d/%h exp=1/7/0000bbbb", regfile_write, rdc, rd); else passes++;
    tick();
    checks++; if (regfile_write !== 1'b0) $display("FAIL waw_dead_pop got=%b exp=0", regfile_write); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL waw_drain got=%0d exp=0", fifo_count); else passes++;
    alu_wvalid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
    mdu_wvalid = 1'b1; mdu_waddr = 5'd3; mdu_wdata = 32'h44;
    tick();
    idle();
    checks++; if (pend_mask !== 32'h0) $display("FAIL waw_same_pend got=%h exp=0", pend_mask); else passes++;
    checks++; if (fifo_count !== 3'd1) $display("FAIL waw_same_count got=%0d exp=1", fifo_count); else passes++;
    checks++; if (rd !== 32'h33) $display("FAIL waw_same_rd got=%h exp=33", rd); else passes++;
    tick();
    checks++; if (regfile_write !== 1'b0) $display("FAIL waw_same_pop got=%b exp=0", regfile_write); else passes++;
  endtask

  task automatic test_r0();
    mdu_wvalid = 1'b1; mdu_waddr = 5'd0; mdu_wdata = 32'hDEAD;
    checks++; if (mdu_wready !== 1'b1) $display("FAIL r0_ready got=%b exp=1", mdu_wready); else passes++;
    tick();
    checks++; if (regfile_write !== 1'b0) $display("FAIL r0_mdu_we got=%b exp=0", regfile_write); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL r0_mdu_count got=%0d exp=0", fifo_count); else passes++;
    alu_wvalid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hBEEF;
    tick();
    idle();
    checks++; if (regfile_write !== 1'b0) $display("FAIL r0_alu_we got=%b exp=0", regfile_write); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL r0_alu_count got=%0d exp=0", fifo_count); else passes++;
    tick();
    checks++; if (regfile_write !== 1'b0) $display("FAIL r0_after_we got=%b exp=0", regfile_write); else passes++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      alu_wvalid = 1'b1; alu_waddr = 5'(1 + i); alu_wdata = 32'(i);
      mdu_wvalid = 1'b1; mdu_waddr = 5'(20 + i); mdu_wdata = 32'(100 + i);
      tick();
    end
    alu_waddr = 5'd4; mdu_wvalid = 1'b0;
    tick();
    idle();
    checks++; if (fifo_count !== 3'd3) $display("FAIL arst_pre_count got=%0d exp=3", fifo_count); else passes++;
    checks++; if (pend_mask !== 32'h0070_0000) $display("FAIL arst_pre_pend got=%h exp=00700000", pend_mask); else passes++;
    #2 wb_rst_n = 1'b0;
    #1;
    checks++; if (regfile_write !== 1'b0 || rdc !== 5'd0 || rd !== 32'd0)
      $display("FAIL arst_out got=%b/%0d/%h exp=0/0/0", regfile_write, rdc, rd); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL arst_count got=%0d exp=0", fifo_count); else passes++;
    checks++; if (pend_mask !== 32'd0) $display("FAIL arst_pend got=%h exp=0", pend_mask); else passes++;
    #1 wb_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (regfile_write !== 1'b0 || fifo_count !== 3'd0)
        $display("FAIL arst_stale i=%0d got=%b/%0d exp=0/0", i, regfile_write, fifo_count); else passes++;
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_fwd();
    alu_wvalid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1;
    mdu_wvalid = 1'b1; mdu_waddr = 5'd9; mdu_wdata = 32'h11;
    tick();
    alu_waddr = 5'd2; mdu_wdata = 32'h22;
    tick();
    idle();
    fwd_addr = 5'd9;
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22)
      $display("FAIL fwd_young got=%b/%h exp=1/22", fwd_hit, fwd_data); else passes++;
    fwd_addr = 5'd0;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0)
      $display("FAIL fwd_r0 got=%b/%h exp=0/0", fwd_hit, fwd_data); else passes++;
    for (int i = 0; i < 3; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_mdu_direct();
    test_collide();
    test_waw();
    test_r0();
    test_async_reset();
`ifdef WB_FWD_EN
    test_fwd();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the 32x32 register file. Merges single-cycle ALU results and multi-cycle MDU (mul/div) results into the file's single write port (rdc, rd, regfile_write).
- MDU results that collide with ALU writes are buffered in a small FIFO.
- Drives a per-register pending mask so decode stalls on RAW hazards against buffered results.
- Sits between the execute stage and the register file.

Parameters:
- DEPTH, 4, MDU write-buffer entries (power of 2, 2..16).
- AW, 2, log2(DEPTH); pointer width.

Ports:
- wb_clk  in  1  clock; all state updates on rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- alu_wvalid  in  1  ALU result valid this cycle; cannot be stalled.
- alu_waddr  in  5  ALU destination register.
- alu_wdata  in  32  ALU result.
- mdu_wvalid  in  1  MDU result valid.
- mdu_wready  out  1  arbiter can accept an MDU result.
- mdu_waddr  in  5  MDU destination register.
- mdu_wdata  in  32  MDU result.
- regfile_write  out  1  register-file write enable.
- rdc  out  5  register-file write address.
- rd  out  32  register-file write data.
- pend_mask  out  32  bit i set = a live buffered write to register i exists.
- fifo_count  out  AW+1  current buffer occupancy.

Behaviour:
- Reset (async, wb_rst_n low): FIFO empty, pointers 0, all valid bits 0, regfile_write=0, rdc=0, rd=0, pend_mask=0, fifo_count=0. mdu_wready reads 1 once reset deasserts. Reset mid-operation discards all buffered results.
- Output stage: regfile_write/rdc/rd are registered. A write selected in cycle N appears on the port in cycle N+1.
- Selection each cycle, in priority order:
  1. ALU: if alu_wvalid, output stage loads the ALU write.
  2. FIFO: else if FIFO non-empty, pop head. Load it if its live bit is set; else regfile_write=0 that cycle.
  3. MDU direct: else if MDU handshake completes with FIFO empty, bypass the FIFO and load the MDU write (1-cycle latency).
  4. Otherwise regfile_write=0.
- Enqueue: MDU handshake (mdu_wvalid && mdu_wready) not consumed by the direct path pushes {addr, data, live=1}.
- Simultaneous push and pop: allowed; count unchanged.
- mdu_wready = (fifo_count < DEPTH), combinational from registered count. When full, a same-cycle pop does not raise ready.
- Register 0:
  - ALU or MDU write with address 0 yields regfile_write=0.
  - MDU handshake to address 0 completes but is discarded: not enqueued, no slot consumed.
- WAW kill: an ALU write to address X (X!=0) clears the live bit of every FIFO entry with addr X. An MDU result to X accepted in the same cycle is enqueued with live=0. ALU is always the younger producer.
- pend_mask: combinational OR over entries with live=1 of onehot(addr). Excludes the output stage and register 0.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- No X on any output after reset.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, adds ports:
  - fwd_addr  in  5  lookup address.
  - fwd_hit  out  1  a buffered or in-flight value exists for fwd_addr.
  - fwd_data  out  32  that value.
- Lookup is combinational. Search order: youngest live FIFO entry, then the output stage (regfile_write && rdc==fwd_addr).
- fwd_addr=0 gives fwd_hit=0, fwd_data=0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then MDU write r5=0x12345678 with no ALU traffic -> next cycle regfile_write=1, rdc=5, rd=0x12345678. pend_mask stays 0. mdu_wready=1 throughout.
- ALU writes r1..r6 on 6 consecutive cycles while MDU offers r8..r13 -> ALU writes appear in order, 1 cycle late. MDU accepts 4 results, then mdu_wready=0. After ALU stops, r8..r11 drain in order, then r12, r13. fifo_count peaks at 4. pend_mask bits 8..11 set until each pops.
- MDU r7=0xAAAA buffered behind ALU traffic, then ALU writes r7=0xBBBB -> r7's pend bit clears immediately. The later pop gives regfile_write=0. Final r7 write observed is 0xBBBB only.
- MDU write to r0 and ALU write to r0 -> handshake completes, fifo_count unchanged, regfile_write never asserted.
- wb_rst_n pulsed low asynchronously between clock edges with 3 entries buffered -> outputs zero immediately, fifo_count=0, pend_mask=0, no stale write after release.
- (WB_FWD_EN) Buffered r9=0x11 then r9=0x22, fwd_addr=9 -> fwd_hit=1, fwd_data=0x22. fwd_addr=0 -> fwd_hit=0.
